relu_pool: RTL and testbench

//  Post-processing stage downstream of the accumulator/out_mux path. Consumes the packed 4-lane

---
 rtl/relu_pool.sv | 181 ++++++++++++++++++
 tb/tb_relu_pool.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool.sv
// relu_pool: per-lane ReLU followed by 2x2/stride-2 max pooling over a raster pixel stream.
// Optional feature macro: RELU_CLIP_EN (clamp each lane to CLIP_MAX after ReLU).
module relu_pool #(
    parameter int                DATA_W   = 16,
    parameter int                LANES    = 4,
    parameter int                COLS     = 8,
    parameter int                ROWS     = 8,
    parameter logic [DATA_W-1:0] CLIP_MAX = 16'h7FFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W*LANES-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic [15:0]               out_addr,
    output logic                      busy,
    output logic                      done
);

    localparam int WORD_W = DATA_W * LANES;
    localparam int COL_W  = (COLS > 2) ? $clog2(COLS) : 1;
    localparam int ROW_W  = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int LB_D   = COLS / 2;
    localparam int LB_AW  = (LB_D > 1) ? $clog2(LB_D) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    // A negative clip bound is meaningless after ReLU, so it is rejected with the odd sizes.
    generate
        if ((COLS % 2) != 0 || COLS < 2 || (ROWS % 2) != 0 || ROWS < 2 || CLIP_MAX[DATA_W-1]) begin : g_bad_cfg
            $error("relu_pool: COLS/ROWS must be even and >= 2, CLIP_MAX must be non-negative");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] relu_lane(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        if (x[DATA_W-1]) r = {DATA_W{1'b0}};
        else             r = x;
`ifdef RELU_CLIP_EN
        if (r > CLIP_MAX) r = CLIP_MAX;
        else              r = r;
`endif
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] max_lane(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    state_t              state_r;
    logic [COL_W-1:0]    col_r;
    logic [ROW_W-1:0]    row_r;
    logic [WORD_W-1:0]   h_r;
    logic [WORD_W-1:0]   lbuf_r [LB_D];
    logic                out_valid_r;
    logic [WORD_W-1:0]   out_data_r;
    logic [15:0]         out_addr_r;
    logic                busy_r;
    logic                done_r;

    logic [WORD_W-1:0]   relu_s;
    logic [WORD_W-1:0]   hmax_s;
    logic [WORD_W-1:0]   pooled_s;
    logic [LB_AW-1:0]    lb_idx_s;
    logic                in_ready_s;
    logic                in_fire_s;
    logic                out_fire_s;

    // Input is held off only while a pooled word is stuck in the output register.
    always_comb begin
        in_ready_s = (state_r == S_RUN) && !(out_valid_r && !out_ready);
        in_fire_s  = in_valid && in_ready_s;
        out_fire_s = out_valid_r && out_ready;
        lb_idx_s   = LB_AW'(col_r >> 1);
    end

    // Lane-wise ReLU, horizontal max and vertical max against the line buffer.
    always_comb begin
        relu_s   = {WORD_W{1'b0}};
        hmax_s   = {WORD_W{1'b0}};
        pooled_s = {WORD_W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            relu_s[l*DATA_W +: DATA_W]   = relu_lane(in_data[l*DATA_W +: DATA_W]);
            hmax_s[l*DATA_W +: DATA_W]   = max_lane(h_r[l*DATA_W +: DATA_W],
                                                    relu_s[l*DATA_W +: DATA_W]);
            pooled_s[l*DATA_W +: DATA_W] = max_lane(lbuf_r[lb_idx_s][l*DATA_W +: DATA_W],
                                                    hmax_s[l*DATA_W +: DATA_W]);
        end
    end

    // Control FSM, raster counters, line buffer and the single-entry output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            col_r       <= {COL_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            h_r         <= {WORD_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {WORD_W{1'b0}};
            out_addr_r  <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < LB_D; i++) begin
                lbuf_r[i] <= {WORD_W{1'b0}};
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r    <= S_RUN;
                        busy_r     <= 1'b1;
                        col_r      <= {COL_W{1'b0}};
                        row_r      <= {ROW_W{1'b0}};
                        out_addr_r <= 16'd0;
                    end
                end
                S_RUN: begin
                    if (out_fire_s) begin
                        out_valid_r <= 1'b0;
                        out_addr_r  <= out_addr_r + 16'd1;
                    end
                    if (in_fire_s) begin
                        if (!col_r[0]) begin
                            h_r <= relu_s;
                        end else if (!row_r[0]) begin
                            lbuf_r[lb_idx_s] <= hmax_s;
                        end else begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= pooled_s;
                        end
                        if (col_r == COL_MAX) begin
                            col_r <= {COL_W{1'b0}};
                            if (row_r == ROW_MAX) begin
                                row_r   <= {ROW_W{1'b0}};
                                state_r <= S_FLUSH;
                            end else begin
                                row_r <= row_r + ROW_W'(1);
                            end
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (out_fire_s) begin
                        out_valid_r <= 1'b0;
                        out_addr_r  <= out_addr_r + 16'd1;
                        state_r     <= S_IDLE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_addr  = out_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_relu_pool.sv
// Bench for relu_pool: three instances (4x2, 8x8, 2x2 with CLIP_MAX=600) share one driver.
module tb_relu_pool;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;
    logic [2:0]  mask;

    logic [2:0]  ir, ov, bz, dn;
    logic [63:0] od [3];
    logic [15:0] oa [3];

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    int done_cnt = 0;
    int exp_addr = 0;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    typedef struct {
        logic [63:0] p0, p1, p2, p3;
        logic [63:0] exp;
    } vec_t;
    vec_t vt [5];

    logic [63:0] pix [8][8];

`ifdef RELU_CLIP_EN
    localparam logic [15:0] CLIP_EXP = 16'd600;
`else
    localparam logic [15:0] CLIP_EXP = 16'd700;
`endif

    always #5 clk = ~clk;

    relu_pool #(.COLS(4), .ROWS(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start & mask[0]), .in_valid(in_valid & mask[0]),
        .in_ready(ir[0]), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready & mask[0]),
        .out_data(od[0]), .out_addr(oa[0]), .busy(bz[0]), .done(dn[0]));

    relu_pool u_b (
        .clk(clk), .rst_n(rst_n), .start(start & mask[1]), .in_valid(in_valid & mask[1]),
        .in_ready(ir[1]), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready & mask[1]),
        .out_data(od[1]), .out_addr(oa[1]), .busy(bz[1]), .done(dn[1]));

    relu_pool #(.COLS(2), .ROWS(2), .CLIP_MAX(16'd600)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start & mask[2]), .in_valid(in_valid & mask[2]),
        .in_ready(ir[2]), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready & mask[2]),
        .out_data(od[2]), .out_addr(oa[2]), .busy(bz[2]), .done(dn[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu16(input logic [15:0] x);
        return x[15] ? 16'd0 : x;
    endfunction

    // Reference: max of ReLU over the 2x2 window ending at (r, c).
    function automatic logic [63:0] pool_ref(input int r, input int c);
        logic [63:0] res;
        logic [15:0] m, v;
        res = 64'd0;
        for (int l = 0; l < 4; l++) begin
            m = 16'd0;
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    v = relu16(pix[r-dr][c-dc][63-16*l -: 16]);
                    if (v > m) m = v;
                end
            end
            res[63-16*l -: 16] = m;
        end
        return res;
    endfunction

    // Scoreboard: every accepted output is popped and checked in order.
    always @(negedge clk) begin
        if (rst_n && ov[cur] && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got addr %0d data %h want nothing", oa[cur], od[cur]);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", od[cur], mon_e.data);
                chk("out_addr", {48'd0, oa[cur]}, {48'd0, mon_e.addr});
            end
        end
        if (rst_n && dn[cur]) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int s);
        cur   = s;
        mask  = 3'b001 << s;
        start = 1'b1;
        tick();
        start    = 1'b0;
        exp_addr = 0;
        chk("busy_after_start", {63'd0, bz[s]}, 64'd1);
    endtask

    task automatic send_px(input int s, input int r, input int c,
                           input bit use_tab, input logic [63:0] tab_exp);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_data  = pix[r][c];
        in_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            if (ir[s]) acc = 1'b1;
            else       n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: pixel r=%0d c=%0d got no in_ready want accept", r, c);
        end else if ((r % 2 == 1) && (c % 2 == 1)) begin
            q.push_back('{addr: 16'(exp_addr), data: (use_tab ? tab_exp : pool_ref(r, c))});
            exp_addr++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int s, input int cols, input int first, input int last,
                              input bit use_tab, input logic [63:0] tab_exp);
        for (int i = first; i <= last; i++) begin
            send_px(s, i / cols, i % cols, use_tab, tab_exp);
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_plane(input int s, input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || bz[s]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
        chk({name, "_busy_low"}, {63'd0, bz[s]}, 64'd0);
        chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
        done_cnt = 0;
        tick();
    endtask

    task automatic backpressure();
        int n;
        logic [63:0] cap_d;
        logic [15:0] cap_a;
        n = 0;
        while (!ov[1] && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ov[1] && n < 300) begin
            @(negedge clk);
            n++;
        end
        cap_d = od[1];
        cap_a = oa[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", {63'd0, ov[1]}, 64'd1);
            chk("bp_data_held", od[1], cap_d);
            chk("bp_addr_held", {48'd0, oa[1]}, {48'd0, cap_a});
            chk("bp_in_ready_low", {63'd0, ir[1]}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{64'h0001_0002_0003_0004, 64'hFFFF_FFFE_FFFD_FFFC, 64'h0,
                  64'h0004_0003_0002_0001, 64'h0004_0003_0003_0004};
        vt[1] = '{64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_0001,
                  64'h8000_8000_8000_8000, 64'h0000_0000_0000_0001};
        vt[2] = '{64'h0258_0000_0000_0000, 64'h0257_0001_FFFF_0000, 64'h0,
                  64'h0000_0000_0000_0100, 64'h0258_0001_0000_0100};
        vt[3] = '{64'h0010_0020_0030_0040, 64'h0011_0021_0031_0041, 64'h0100_0200_0001_0002,
                  64'h0, 64'h0100_0200_0031_0041};
        vt[4] = '{64'h0064_0000_0000_0000, 64'h02BC_0000_0000_0000, 64'hFFFD_0000_0000_0000,
                  64'h0032_0000_0000_0000, {CLIP_EXP, 48'h0}};

        // Reset held with start and in_valid asserted on every instance.
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; mask = 3'b111; out_ready = 1'b1;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", {63'd0, ir[k]}, 64'd0);
            chk("rst_out_valid", {63'd0, ov[k]}, 64'd0);
            chk("rst_out_data", od[k], 64'd0);
            chk("rst_out_addr", {48'd0, oa[k]}, 64'd0);
            chk("rst_busy", {63'd0, bz[k]}, 64'd0);
            chk("rst_done", {63'd0, dn[k]}, 64'd0);
        end
        start = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", {63'd0, bz[1]}, 64'd0);
        chk("idle_in_ready", {63'd0, ir[1]}, 64'd0);

        // 4x2 plane, lane0 = 1..8, other lanes -5.
        for (int i = 0; i < 8; i++) pix[i/4][i%4] = {16'(i + 1), 16'hFFFB, 16'hFFFB, 16'hFFFB};
        pulse_start(0);
        send_range(0, 4, 0, 4, 1'b0, 64'd0);
        send_px(0, 1, 1, 1'b1, 64'h0006_0000_0000_0000);
        send_px(0, 1, 2, 1'b0, 64'd0);
        send_px(0, 1, 3, 1'b1, 64'h0008_0000_0000_0000);
        finish_plane(0, "t2");

        // All-negative 8x8 plane.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) pix[r][c] = 64'h8000_8000_8000_8000;
        pulse_start(1);
        send_range(1, 8, 0, 63, 1'b1, 64'd0);
        finish_plane(1, "t3");

        // Random 8x8 plane with a backpressure window.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) pix[r][c] = {$urandom, $urandom};
        pulse_start(1);
        fork
            send_range(1, 8, 0, 63, 1'b0, 64'd0);
            backpressure();
        join
        finish_plane(1, "t4");

        // Mid-plane start (ignored), mid-plane reset, then a fresh plane.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) pix[r][c] = {$urandom, $urandom} | 64'h7000_7000_7000_7000;
        pulse_start(1);
        send_range(1, 8, 0, 27, 1'b0, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_busy", {63'd0, bz[1]}, 64'd1);
        send_range(1, 8, 28, 31, 1'b0, 64'd0);
        wait_empty();
        chk("midstart_drained", 64'(q.size()), 64'd0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        chk("midrst_out_valid", {63'd0, ov[1]}, 64'd0);
        chk("midrst_busy", {63'd0, bz[1]}, 64'd0);
        chk("midrst_addr", {48'd0, oa[1]}, 64'd0);
        done_cnt = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) pix[r][c] = {$urandom, $urandom} & 64'h00FF_00FF_00FF_00FF;
        pulse_start(1);
        send_range(1, 8, 0, 63, 1'b0, 64'd0);
        finish_plane(1, "t5");

        // Table of 2x2 planes, last entry exercises the clip bound.
        for (int v = 0; v < 5; v++) begin
            pix[0][0] = vt[v].p0;
            pix[0][1] = vt[v].p1;
            pix[1][0] = vt[v].p2;
            pix[1][1] = vt[v].p3;
            pulse_start(2);
            send_px(2, 0, 0, 1'b0, 64'd0);
            send_px(2, 0, 1, 1'b0, 64'd0);
            send_px(2, 1, 0, 1'b0, 64'd0);
            send_px(2, 1, 1, 1'b1, vt[v].exp);
            finish_plane(2, "tab");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
